mem_bus_arbiter: RTL and testbench

//  Shares one SRAM-like memory bus between the fetch port (inst) and the memory-stage load/store port (data).

---
 rtl/mem_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch port and the load/store port.
// One transaction in flight; data has priority, with a starvation counter that guarantees fetch progress.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // fetch port
  input  logic                    inst_req,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic                    inst_addr_ok,
  output logic                    inst_data_ok,
  output logic [DATA_WIDTH-1:0]   inst_rdata,
  // load/store port
  input  logic                    data_req,
  input  logic                    data_wr,
  input  logic [1:0]              data_size,
  input  logic [DATA_WIDTH/8-1:0] data_wstrb,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  output logic                    data_addr_ok,
  output logic                    data_data_ok,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  input  logic                    flush,
  // downstream bus
  output logic                    bus_req,
  output logic                    bus_wr,
  output logic [1:0]              bus_size,
  output logic [DATA_WIDTH/8-1:0] bus_wstrb,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  input  logic                    bus_addr_ok,
  input  logic                    bus_data_ok,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  output logic                    busy,
  output logic [1:0]              fsm_state
);

  // Handshake contract: a requester holds req and its payload until it sees
  // addr_ok in the same cycle; data_ok is a single-cycle pulse to the owner.

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  state_e         state, state_next;
  owner_e         owner;
  logic           win_inst;
  logic           drop;
  logic [CW-1:0]  starve_cnt;

  logic           any_req;
  logic           pick_inst;
  logic           addr_fire;
  logic           resp_fire;

  assign any_req   = inst_req | data_req;
  assign pick_inst = inst_req & (~data_req | (starve_cnt == LIMIT));
  assign addr_fire = (state == ST_ADDR) & bus_addr_ok;
  assign resp_fire = (state == ST_WAIT) & bus_data_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (any_req) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        // An accepted address always wins over flush; an unaccepted fetch can be withdrawn.
        if (bus_addr_ok) begin
          state_next = ST_WAIT;
        end else if (flush && win_inst) begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus_data_ok) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Payload is captured once in IDLE and held stable through ADDR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_inst  <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= 2'd0;
      bus_wstrb <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (state == ST_IDLE && any_req) begin
      win_inst <= pick_inst;
      if (pick_inst) begin
        bus_wr    <= 1'b0;
        bus_size  <= 2'd2;
        bus_wstrb <= '0;
        bus_addr  <= inst_addr;
        bus_wdata <= '0;
      end else begin
        bus_wr    <= data_wr;
        bus_size  <= data_size;
        bus_wstrb <= data_wstrb;
        bus_addr  <= data_addr;
        bus_wdata <= data_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= OWN_NONE;
      drop  <= 1'b0;
    end else begin
      if (addr_fire) begin
        owner <= win_inst ? OWN_INST : OWN_DATA;
        drop  <= win_inst & flush;
      end else if (resp_fire) begin
        owner <= OWN_NONE;
        drop  <= 1'b0;
      end else if (state == ST_WAIT && owner == OWN_INST && flush) begin
        drop <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (!inst_req || pick_inst) begin
        starve_cnt <= '0;
      end else if (data_req && starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    busy         = (state != ST_IDLE);
    bus_req      = (state == ST_ADDR);
    fsm_state    = state;
    inst_addr_ok = addr_fire & win_inst;
    data_addr_ok = addr_fire & ~win_inst;
    inst_data_ok = resp_fire & (owner == OWN_INST) & ~drop & ~flush;
    data_data_ok = resp_fire & (owner == OWN_DATA);
    inst_rdata   = inst_data_ok ? bus_rdata : '0;
    data_rdata   = data_data_ok ? bus_rdata : '0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: the bench plays the memory bridge cycle by cycle
// and checks every port against hand-computed values.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok, inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr;
  logic [1:0]    data_size;
  logic [3:0]    data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok, data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          flush;
  logic          bus_req, bus_wr;
  logic [1:0]    bus_size;
  logic [3:0]    bus_wstrb;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok, bus_data_ok;
  logic [DW-1:0] bus_rdata;
  logic          busy;
  logic [1:0]    fsm_state;

  int vectors = 0;
  int miscompares = 0;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .flush(flush),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .busy(busy), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".bus_req"}, 64'(bus_req), 64'd0);
    chk({tag, ".inst_data_ok"}, 64'(inst_data_ok), 64'd0);
    chk({tag, ".data_data_ok"}, 64'(data_data_ok), 64'd0);
    chk({tag, ".inst_addr_ok"}, 64'(inst_addr_ok), 64'd0);
    chk({tag, ".data_addr_ok"}, 64'(data_addr_ok), 64'd0);
    chk({tag, ".bus_addr"}, 64'(bus_addr), 64'd0);
    chk({tag, ".bus_wdata"}, 64'(bus_wdata), 64'd0);
    chk({tag, ".bus_wr"}, 64'(bus_wr), 64'd0);
    chk({tag, ".bus_size"}, 64'(bus_size), 64'd0);
    chk({tag, ".bus_wstrb"}, 64'(bus_wstrb), 64'd0);
    chk({tag, ".inst_rdata"}, 64'(inst_rdata), 64'd0);
    chk({tag, ".fsm_state"}, 64'(fsm_state), 64'd0);
  endtask

  // Plain fetch: IDLE -> ADDR (addr_ok) -> WAIT (data_ok) -> IDLE.
  task automatic fetch_ok(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] rd);
    inst_req = 1'b1; inst_addr = addr;
    cyc();
    bus_addr_ok = 1'b1; settle();
    chk({tag, ".bus_req"}, 64'(bus_req), 64'd1);
    chk({tag, ".bus_addr"}, 64'(bus_addr), 64'(addr));
    chk({tag, ".bus_size"}, 64'(bus_size), 64'd2);
    chk({tag, ".inst_addr_ok"}, 64'(inst_addr_ok), 64'd1);
    cyc();
    inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = rd; settle();
    chk({tag, ".inst_data_ok"}, 64'(inst_data_ok), 64'd1);
    chk({tag, ".inst_rdata"}, 64'(inst_rdata), 64'(rd));
    cyc();
    bus_data_ok = 1'b0; settle();
    chk({tag, ".busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = '0;
    data_addr = '0; data_wdata = '0; flush = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

    // reset state
    repeat (2) cyc();
    chk_quiet("reset");
    rst_n = 1'b1;

    // 1: single fetch with 1-cycle addr latency and data two cycles after addr_ok
    cyc();
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; settle();
    chk("t1.idle_busy", 64'(busy), 64'd0);
    chk("t1.idle_bus_req", 64'(bus_req), 64'd0);
    cyc();
    settle();
    chk("t1.addr_bus_req", 64'(bus_req), 64'd1);
    chk("t1.addr_state", 64'(fsm_state), 64'd1);
    chk("t1.addr_no_ok", 64'(inst_addr_ok), 64'd0);
    cyc();
    bus_addr_ok = 1'b1; settle();
    chk("t1.inst_addr_ok", 64'(inst_addr_ok), 64'd1);
    chk("t1.data_addr_ok", 64'(data_addr_ok), 64'd0);
    chk("t1.bus_wr", 64'(bus_wr), 64'd0);
    chk("t1.bus_wstrb", 64'(bus_wstrb), 64'd0);
    cyc();
    inst_req = 1'b0; bus_addr_ok = 1'b0; settle();
    chk("t1.wait_bus_req", 64'(bus_req), 64'd0);
    chk("t1.wait_busy", 64'(busy), 64'd1);
    chk("t1.wait_addr_ok", 64'(inst_addr_ok), 64'd0);
    chk("t1.wait_no_data", 64'(inst_data_ok), 64'd0);
    cyc();
    bus_data_ok = 1'b1; bus_rdata = 32'h0280_0000; settle();
    chk("t1.inst_data_ok", 64'(inst_data_ok), 64'd1);
    chk("t1.inst_rdata", 64'(inst_rdata), 64'h0280_0000);
    chk("t1.data_data_ok", 64'(data_data_ok), 64'd0);
    cyc();
    bus_data_ok = 1'b0; settle();
    chk("t1.done_busy", 64'(busy), 64'd0);
    chk("t1.done_data_ok", 64'(inst_data_ok), 64'd0);

    // 2: simultaneous fetch and store, store first
    inst_req = 1'b1; inst_addr = 32'h1C00_0010;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 32'h0000_1000; data_wdata = 32'hDEAD_BEEF;
    cyc();
    bus_addr_ok = 1'b1; settle();
    chk("t2.bus_wr", 64'(bus_wr), 64'd1);
    chk("t2.bus_addr", 64'(bus_addr), 64'h1000);
    chk("t2.bus_wstrb", 64'(bus_wstrb), 64'hF);
    chk("t2.bus_wdata", 64'(bus_wdata), 64'hDEAD_BEEF);
    chk("t2.data_addr_ok", 64'(data_addr_ok), 64'd1);
    chk("t2.inst_addr_ok", 64'(inst_addr_ok), 64'd0);
    cyc();
    data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0; settle();
    chk("t2.data_data_ok", 64'(data_data_ok), 64'd1);
    chk("t2.inst_data_ok_st", 64'(inst_data_ok), 64'd0);
    cyc();
    bus_data_ok = 1'b0;
    cyc();
    bus_addr_ok = 1'b1; settle();
    chk("t2.fetch_addr", 64'(bus_addr), 64'h1C00_0010);
    chk("t2.fetch_wr", 64'(bus_wr), 64'd0);
    chk("t2.fetch_addr_ok", 64'(inst_addr_ok), 64'd1);
    cyc();
    inst_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1111_2222; settle();
    chk("t2.fetch_data_ok", 64'(inst_data_ok), 64'd1);
    chk("t2.fetch_rdata", 64'(inst_rdata), 64'h1111_2222);
    cyc();
    bus_data_ok = 1'b0;

    // 3: starvation, 10 grants with both requests held: inst wins 5th and 10th
    inst_req = 1'b1; inst_addr = 32'h1C00_0020;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0; data_addr = 32'h2000;
    for (int g = 0; g < 10; g++) begin
      logic exp_i;
      exp_i = (g == 4) || (g == 9);
      cyc();
      bus_addr_ok = 1'b1; settle();
      chk($sformatf("t3.g%0d.inst_addr_ok", g), 64'(inst_addr_ok), 64'(exp_i));
      chk($sformatf("t3.g%0d.data_addr_ok", g), 64'(data_addr_ok), 64'(!exp_i));
      cyc();
      bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h100 + 32'(g); settle();
      chk($sformatf("t3.g%0d.inst_data_ok", g), 64'(inst_data_ok), 64'(exp_i));
      chk($sformatf("t3.g%0d.data_data_ok", g), 64'(data_data_ok), 64'(!exp_i));
      cyc();
      bus_data_ok = 1'b0;
    end
    inst_req = 1'b0; data_req = 1'b0;
    cyc();

    // 4: flush during WAIT of a fetch, then a normal fetch
    inst_req = 1'b1; inst_addr = 32'h1C00_0030;
    cyc();
    bus_addr_ok = 1'b1; settle();
    chk("t4.inst_addr_ok", 64'(inst_addr_ok), 64'd1);
    cyc();
    inst_req = 1'b0; bus_addr_ok = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hBAD0_BAD0; settle();
    chk("t4.dropped_data_ok", 64'(inst_data_ok), 64'd0);
    chk("t4.dropped_rdata", 64'(inst_rdata), 64'd0);
    cyc();
    bus_data_ok = 1'b0; settle();
    chk("t4.idle_busy", 64'(busy), 64'd0);
    fetch_ok("t4.next", 32'h1C00_0034, 32'h0340_0001);

    // 5: flush in ADDR of a fetch withdraws it; flush in WAIT of a load is ignored
    inst_req = 1'b1; inst_addr = 32'h1C00_0040;
    cyc();
    flush = 1'b1; settle();
    chk("t5.bus_req_before", 64'(bus_req), 64'd1);
    chk("t5.no_addr_ok", 64'(inst_addr_ok), 64'd0);
    cyc();
    inst_req = 1'b0; flush = 1'b0; settle();
    chk("t5.withdrawn_bus_req", 64'(bus_req), 64'd0);
    chk("t5.withdrawn_busy", 64'(busy), 64'd0);
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h3001;
    cyc();
    bus_addr_ok = 1'b1; settle();
    chk("t5.load_size", 64'(bus_size), 64'd0);
    chk("t5.load_addr_ok", 64'(data_addr_ok), 64'd1);
    cyc();
    data_req = 1'b0; bus_addr_ok = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0000_0055; settle();
    chk("t5.load_data_ok", 64'(data_data_ok), 64'd1);
    chk("t5.load_rdata", 64'(data_rdata), 64'h55);
    cyc();
    bus_data_ok = 1'b0;

    // flush coincident with addr_ok of a fetch: accepted, response dropped
    inst_req = 1'b1; inst_addr = 32'h1C00_0050;
    cyc();
    flush = 1'b1; bus_addr_ok = 1'b1; settle();
    chk("t5b.inst_addr_ok", 64'(inst_addr_ok), 64'd1);
    cyc();
    inst_req = 1'b0; flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b1; settle();
    chk("t5b.wait_busy", 64'(busy), 64'd1);
    chk("t5b.dropped", 64'(inst_data_ok), 64'd0);
    cyc();
    bus_data_ok = 1'b0;

    // flush coincident with data_ok of a fetch: dropped
    inst_req = 1'b1; inst_addr = 32'h1C00_0060;
    cyc();
    bus_addr_ok = 1'b1;
    cyc();
    inst_req = 1'b0; bus_addr_ok = 1'b0; flush = 1'b1; bus_data_ok = 1'b1; settle();
    chk("t5c.dropped", 64'(inst_data_ok), 64'd0);
    cyc();
    flush = 1'b0; bus_data_ok = 1'b0; settle();
    chk("t5c.idle", 64'(busy), 64'd0);

    // 6: reset asserted in WAIT, then a fresh fetch
    inst_req = 1'b1; inst_addr = 32'h1C00_0070;
    cyc();
    bus_addr_ok = 1'b1;
    cyc();
    inst_req = 1'b0; bus_addr_ok = 1'b0; settle();
    chk("t6.wait_busy", 64'(busy), 64'd1);
    bus_data_ok = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    #2 rst_n = 1'b0;
    settle();
    chk_quiet("t6.reset");
    cyc();
    bus_data_ok = 1'b0; rst_n = 1'b1;
    cyc();
    fetch_ok("t6.fresh", 32'h1C00_0000, 32'h0280_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
